cpu_sequencer: RTL and testbench

// Microprogrammed-style control FSM for the 8-bit accumulator CPU datapath (PC, MAR, ROM, DR, A, ALU, IR).

---
 rtl/cpu_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Control sequencer for the 8-bit accumulator CPU: drives the datapath strobes and
// the T-state one-hot, with run/single-step control, HALT, sticky illegal flag and retire counter.
module cpu_sequencer #(
    parameter int CNT_W = 8,
    parameter int OP_W  = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             RUN,
    input  logic             STEP,
    input  logic [OP_W-1:0]  IR_OP,
    output logic             IMAR,
    output logic             IPC,
    output logic             IDR,
    output logic             EDR,
    output logic             IIR,
    output logic             IA,
    output logic             EA,
    output logic             EALU,
    output logic             ISUM,
    output logic             ISUB,
    output logic             IAND,
    output logic             IOR,
    output logic             ISHL,
    output logic             IXOR,
    output logic [7:0]       T,
    output logic             BUSY,
    output logic             HALTED,
    output logic             ILLEGAL,
    output logic [CNT_W-1:0] INSTR_CNT
);

    localparam logic [OP_W-1:0] OP_NOP  = OP_W'(4'h0);
    localparam logic [OP_W-1:0] OP_LD   = OP_W'(4'h1);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(4'h2);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(4'h3);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(4'h4);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(4'h5);
    localparam logic [OP_W-1:0] OP_SHL  = OP_W'(4'h6);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4'h7);
    localparam logic [OP_W-1:0] OP_HALT = OP_W'(4'hF);

    typedef enum logic [3:0] {
        S_IDLE,
        S_F0,
        S_F1,
        S_F2,
        S_DEC,
        S_O0,
        S_O1,
        S_X,
        S_WB,
        S_HALTED
    } state_t;

    state_t           state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ill_q, ill_d;

    function automatic logic is_alu(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
        end
    end

    // Instruction boundary ("end"): retire, then continue only while RUN is held.
    always_comb begin
        logic retire;
        retire  = 1'b0;
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        ill_d   = ill_q;
        case (state_q)
            S_IDLE: if (RUN || STEP) state_d = S_F0;
            S_F0:   state_d = S_F1;
            S_F1:   state_d = S_F2;
            S_F2:   state_d = S_DEC;
            S_DEC: begin
                op_d = IR_OP;
                if ((IR_OP == OP_LD) || is_alu(IR_OP)) begin
                    state_d = S_O0;
                end else if (IR_OP == OP_SHL) begin
                    state_d = S_X;
                end else if (IR_OP == OP_HALT) begin
                    state_d = S_HALTED;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
                    if (IR_OP != OP_NOP) ill_d = 1'b1;
                    retire = 1'b1;
                end
            end
            S_O0:   state_d = S_O1;
            S_O1:   state_d = S_X;
            S_X: begin
                if (op_q == OP_LD) retire = 1'b1;
                else               state_d = S_WB;
            end
            S_WB:     retire = 1'b1;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
        if (retire) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = RUN ? S_F0 : S_IDLE;
        end
    end

    always_comb begin
        IMAR = 1'b0;
        IPC  = 1'b0;
        IDR  = 1'b0;
        EDR  = 1'b0;
        IIR  = 1'b0;
        IA   = 1'b0;
        EA   = 1'b0;
        EALU = 1'b0;
        ISUM = 1'b0;
        ISUB = 1'b0;
        IAND = 1'b0;
        IOR  = 1'b0;
        ISHL = 1'b0;
        IXOR = 1'b0;
        T    = 8'h00;
        case (state_q)
            S_F0: begin
                T[0] = 1'b1;
                IMAR = 1'b1;
                IPC  = 1'b1;
            end
            S_F1: begin
                T[1] = 1'b1;
                IDR  = 1'b1;
            end
            S_F2: begin
                T[2] = 1'b1;
                EDR  = 1'b1;
                IIR  = 1'b1;
            end
            S_DEC: T[3] = 1'b1;
            S_O0: begin
                T[4] = 1'b1;
                IMAR = 1'b1;
                IPC  = 1'b1;
            end
            S_O1: begin
                T[5] = 1'b1;
                IDR  = 1'b1;
            end
            S_X: begin
                T[6] = 1'b1;
                // SHL works on A alone, so the DR bus stays released.
                EDR  = (op_q != OP_SHL);
                IA   = (op_q == OP_LD);
                ISUM = (op_q == OP_ADD);
                ISUB = (op_q == OP_SUB);
                IAND = (op_q == OP_AND);
                IOR  = (op_q == OP_OR);
                IXOR = (op_q == OP_XOR);
                ISHL = (op_q == OP_SHL);
            end
            S_WB: begin
                T[7] = 1'b1;
                EALU = 1'b1;
                IA   = 1'b1;
            end
            default: T = 8'h00;
        endcase
    end

    assign BUSY      = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign HALTED    = (state_q == S_HALTED);
    assign ILLEGAL   = ill_q;
    assign INSTR_CNT = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: a small datapath harness (ROM, PC, MAR, DR, IR, A, ALU) driven by the
// sequencer strobes, an ISA-level reference model and a scoreboard checked on every retirement.
module tb_cpu_sequencer;
    localparam int CNT_W = 8;
    localparam int OP_W  = 4;

    logic             CLK = 1'b0;
    logic             RESET, RUN, STEP;
    logic [OP_W-1:0]  IR_OP;
    logic             IMAR, IPC, IDR, EDR, IIR, IA, EA, EALU;
    logic             ISUM, ISUB, IAND, IOR, ISHL, IXOR;
    logic [7:0]       T;
    logic             BUSY, HALTED, ILLEGAL;
    logic [CNT_W-1:0] INSTR_CNT;

    always #5 CLK = ~CLK;

    cpu_sequencer #(.CNT_W(CNT_W), .OP_W(OP_W)) dut (
        .CLK(CLK), .RESET(RESET), .RUN(RUN), .STEP(STEP), .IR_OP(IR_OP),
        .IMAR(IMAR), .IPC(IPC), .IDR(IDR), .EDR(EDR), .IIR(IIR), .IA(IA), .EA(EA),
        .EALU(EALU), .ISUM(ISUM), .ISUB(ISUB), .IAND(IAND), .IOR(IOR), .ISHL(ISHL),
        .IXOR(IXOR), .T(T), .BUSY(BUSY), .HALTED(HALTED), .ILLEGAL(ILLEGAL),
        .INSTR_CNT(INSTR_CNT)
    );

    // Datapath harness: registers move only when the sequencer strobes them.
    logic [7:0] rom [16];
    logic [3:0] pc, mar;
    logic [7:0] dr, ir, acc, alu;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc <= 4'h0; mar <= 4'h0; dr <= 8'h00; ir <= 8'h00; acc <= 8'h00; alu <= 8'h00;
        end else begin
            if (IMAR) mar <= pc;
            if (IPC)  pc  <= pc + 4'h1;
            if (IDR)  dr  <= rom[mar];
            if (IIR && EDR) ir <= dr;
            if (IA) acc <= EDR ? dr : (EALU ? alu : acc);
            if (ISUM) alu <= acc + dr;
            if (ISUB) alu <= acc - dr;
            if (IAND) alu <= acc & dr;
            if (IOR)  alu <= acc | dr;
            if (IXOR) alu <= acc ^ dr;
            if (ISHL) alu <= {acc[6:0], 1'b0};
        end
    end
    assign IR_OP = ir[7:4];

    typedef struct {
        int          lat;
        logic [31:0] tseq;
        logic [6:0]  amask;
        logic [7:0]  a;
        logic        ill;
        logic [7:0]  cnt;
    } exp_t;

    exp_t expq[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: executes the ISA one instruction at a time.
    logic [3:0] m_pc;
    logic [7:0] m_a, m_cnt;
    logic       m_ill, m_halt;

    task automatic model_reset();
        m_pc = 4'h0; m_a = 8'h00; m_cnt = 8'h00; m_ill = 1'b0; m_halt = 1'b0;
    endtask

    task automatic model_step();
        exp_t       e;
        logic [7:0] w, imm;
        int         op;
        bit         two, uses_alu;
        w  = rom[m_pc];
        m_pc = m_pc + 4'h1;
        op = int'(w[7:4]);
        two = (op >= 1 && op <= 7 && op != 6);
        uses_alu = (op >= 2 && op <= 7);
        imm = 8'h00;
        if (two) begin
            imm = rom[m_pc];
            m_pc = m_pc + 4'h1;
        end
        e.amask = 7'h00;
        case (op)
            0:  ;
            1:  m_a = imm;
            2:  begin m_a = m_a + imm;  e.amask = 7'h01; end
            3:  begin m_a = m_a - imm;  e.amask = 7'h02; end
            4:  begin m_a = m_a & imm;  e.amask = 7'h04; end
            5:  begin m_a = m_a | imm;  e.amask = 7'h08; end
            6:  begin m_a = m_a << 1;   e.amask = 7'h10; end
            7:  begin m_a = m_a ^ imm;  e.amask = 7'h20; end
            15: m_halt = 1'b1;
            default: m_ill = 1'b1;
        endcase
        e.tseq = 32'h1234;
        e.lat  = 4;
        if (two)     begin e.tseq = (e.tseq << 12) | 32'h567; e.lat += 3; end
        if (op == 6) begin e.tseq = (e.tseq << 4) | 32'h7;    e.lat += 1; end
        if (uses_alu) begin e.tseq = (e.tseq << 4) | 32'h8;   e.lat += 1; e.amask |= 7'h40; end
        m_cnt = m_cnt + 8'h01;
        e.a = m_a; e.ill = m_ill; e.cnt = m_cnt;
        expq.push_back(e);
    endtask

    // Monitor: per-cycle invariants, and a scoreboard pop whenever the DUT retires.
    logic [7:0]  prev_cnt;
    int          lat_c, idx;
    logic [31:0] seq_c;
    logic [6:0]  mask_c;
    exp_t        got;

    always @(negedge CLK or posedge RESET) begin
        if (RESET) begin
            prev_cnt = 8'h00; lat_c = 0; seq_c = 32'h0; mask_c = 7'h00;
        end else begin
            chk("bus_excl", 32'($countones({EDR, EA, EALU}) <= 1), 32'd1);
            chk("t_onehot0", 32'($onehot0(T)), 32'd1);
            chk("busy_vs_t", 32'(BUSY), 32'(T != 8'h00));
            chk("ea_low", 32'(EA), 32'd0);
            if (INSTR_CNT !== prev_cnt) begin
                if (expq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_retire: cnt %0h, expected no retirement", INSTR_CNT);
                end else begin
                    got = expq.pop_front();
                    chk("latency", 32'(lat_c), 32'(got.lat));
                    chk("tseq", seq_c, got.tseq);
                    chk("alu_strobes", 32'(mask_c), 32'(got.amask));
                    chk("acc", 32'(acc), 32'(got.a));
                    chk("illegal", 32'(ILLEGAL), 32'(got.ill));
                    chk("instr_cnt", 32'(INSTR_CNT), 32'(got.cnt));
                end
                prev_cnt = INSTR_CNT; lat_c = 0; seq_c = 32'h0; mask_c = 7'h00;
            end
            if (BUSY) begin
                idx = 0;
                for (int b = 0; b < 8; b++) if (T[b]) idx = b;
                lat_c++;
                seq_c  = (seq_c << 4) | 32'(idx + 1);
                mask_c |= {EALU, IXOR, ISHL, IOR, IAND, ISUB, ISUM};
            end
        end
    end

    function automatic logic [13:0] strobes();
        return {IMAR, IPC, IDR, EDR, IIR, IA, EA, EALU, ISUM, ISUB, IAND, IOR, ISHL, IXOR};
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        #1 RESET = 1'b1; RUN = 1'b0; STEP = 1'b0;
        #1 chk("rst_strobes", 32'(strobes()), 32'd0);
        chk("rst_t", 32'(T), 32'd0);
        #1 RESET = 1'b0;
        expq.delete();
        model_reset();
        #1 chk("rst_cnt", 32'(INSTR_CNT), 32'd0);
        chk("rst_flags", 32'({BUSY, HALTED, ILLEGAL}), 32'd0);
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while ((expq.size() != 0 || BUSY) && n < limit) begin
            @(negedge CLK); #1;
            n++;
        end
        if (n >= limit) begin
            vectors++; miscompares++;
            $display("FAIL wait_timeout: %0d pending, busy %0b, expected drained", expq.size(), BUSY);
            expq.delete();
        end
    endtask

    task automatic step_one(input bit extra);
        if (!m_halt) model_step();
        @(negedge CLK); #1 STEP = 1'b1;
        @(negedge CLK); #1 STEP = 1'b0;
        if (extra) begin
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            #1 STEP = 1'b1;
            @(negedge CLK); #1 STEP = 1'b0;
        end
        wait_done(100);
        chk("step_idle_busy", 32'(BUSY), 32'd0);
        chk("step_halted", 32'(HALTED), 32'(m_halt));
    endtask

    task automatic run_free(input int n);
        int k = 0;
        for (int i = 0; i < n && !m_halt; i++) model_step();
        @(negedge CLK); #1 RUN = 1'b1;
        while (expq.size() != 0 && k < 5000) begin
            @(negedge CLK); #1;
            k++;
        end
        if (k >= 5000) begin
            vectors++; miscompares++;
            $display("FAIL run_timeout: %0d pending, expected 0", expq.size());
            expq.delete();
        end
        RUN = 1'b0;
        if (!m_halt) model_step();
        wait_done(100);
    endtask

    task automatic poke_halted();
        int c0;
        c0 = int'(INSTR_CNT);
        @(negedge CLK); #1 RUN = 1'b1;
        repeat (5) @(negedge CLK);
        #1 RUN = 1'b0; STEP = 1'b1;
        @(negedge CLK); #1 STEP = 1'b0;
        repeat (3) @(negedge CLK);
        #1 chk("halt_sticky", 32'({HALTED, BUSY}), 32'b10);
        chk("halt_cnt", 32'(INSTR_CNT), 32'(c0));
    endtask

    task automatic load_rom(input logic [7:0] b0, b1, b2, b3, b4);
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        rom[0] = b0; rom[1] = b1; rom[2] = b2; rom[3] = b3; rom[4] = b4;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] op;
        RESET = 1'b1; RUN = 1'b0; STEP = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        model_reset();
        repeat (2) @(negedge CLK);
        #1 RESET = 1'b0;

        // NOP keeps ILLEGAL clear, 0x90 sets it and runs as NOP, NOP afterwards keeps it set.
        do_reset();
        load_rom(8'h00, 8'h90, 8'h00, 8'h20, 8'h03);
        step_one(1'b0);
        step_one(1'b1);
        step_one(1'b0);

        // ADD from PC=3, interrupted by reset while in X.
        @(negedge CLK); #1 STEP = 1'b1;
        @(negedge CLK); #1 STEP = 1'b0;
        repeat (6) @(negedge CLK);
        #1 chk("mid_x_t", 32'(T), 32'h40);
        chk("mid_x_isum", 32'(ISUM), 32'd1);
        RESET = 1'b1;
        #1 chk("async_rst_strobes", 32'(strobes()), 32'd0);
        chk("async_rst_t", 32'({T, BUSY, HALTED}), 32'd0);
        #1 RESET = 1'b0;
        expq.delete();
        model_reset();
        #1 chk("post_rst_cnt", 32'(INSTR_CNT), 32'd0);
        chk("post_rst_ill", 32'(ILLEGAL), 32'd0);
        @(negedge CLK); #1 chk("post_rst_idle", 32'(BUSY), 32'd0);

        // LD 5, ADD 3, HALT under RUN.
        do_reset();
        load_rom(8'h10, 8'h05, 8'h20, 8'h03, 8'hF0);
        run_free(10);
        chk("prog1_acc", 32'(acc), 32'h08);
        chk("prog1_cnt", 32'(INSTR_CNT), 32'd3);
        poke_halted();

        // LD 0x0C, SHL, HALT.
        do_reset();
        load_rom(8'h10, 8'h0C, 8'h60, 8'hF0, 8'h00);
        run_free(10);
        chk("prog2_acc", 32'(acc), 32'h18);
        poke_halted();

        // Single-step LD 0x05, with RUN held for only the first cycle of the next NOP.
        do_reset();
        load_rom(8'h10, 8'h05, 8'h00, 8'h00, 8'h00);
        step_one(1'b1);
        model_step();
        @(negedge CLK); #1 RUN = 1'b1;
        @(negedge CLK); #1 RUN = 1'b0;
        wait_done(100);

        // Random programs, alternating single-step and free-run.
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int i = 0; i < 16; i++) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'hF && ($urandom % 3) != 0) op = 4'($urandom_range(0, 7));
                rom[i] = {op, 4'($urandom)};
            end
            if (r % 2 == 0) begin
                for (int s = 0; s < 12; s++) step_one(1'($urandom));
            end else begin
                run_free(int'($urandom_range(4, 14)));
            end
        end

        // Counter wrap over 258 NOPs.
        do_reset();
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        run_free(257);
        chk("wrap_cnt", 32'(INSTR_CNT), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
